// File: rtl/img_pkg.sv
// img_pkg: shared frame geometry, word type and read-state encoding for the dmem image reader
package img_pkg;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PIX_PER_WORD = 16;
  localparam int WORDS_PER_IMG = (NUM_PIX + PIX_PER_WORD - 1) / PIX_PER_WORD;
  localparam int DMEM_AW = 7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;
  typedef logic [255:0] pix_word_t;
endpackage

// File: rtl/dmem_word_prefetch.sv
// dmem_word_prefetch: issues word reads, tracks the read delay line and holds a one-deep prefetch word
module dmem_word_prefetch
  import img_pkg::*;
#(
  parameter logic [DMEM_AW-1:0] BASE_ADDR = 7'd1,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               pop,
  input  logic               flush,
  input  pix_word_t          dmem_q,
  output logic               rden,
  output logic [DMEM_AW-1:0] addr,
  output logic               full,
  output pix_word_t          word
);
  localparam int FW = $clog2(RD_LAT + 1);
  logic [5:0] wcnt_q, wcnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  pix_word_t pf_q, pf_d;
  logic pf_full_q, pf_full_d;
  logic arrive;
  always_comb begin
    arrive = pipe_q[RD_LAT-1] & !flush & (fcnt_q == '0);
    rden = req & !flush & (wcnt_q < 6'(WORDS_PER_IMG)) & (pipe_q == '0) & !pf_full_q;
    addr = rden ? BASE_ADDR + DMEM_AW'(wcnt_q) : '0;
    full = pf_full_q | arrive;
    word = pf_full_q ? pf_q : dmem_q;
    wcnt_d = flush ? '0 : wcnt_q + 6'(rden);
    pipe_d = (pipe_q << 1) | RD_LAT'(rden);
    fcnt_d = flush ? FW'(RD_LAT) : (fcnt_q != '0 ? fcnt_q - 1'b1 : '0);
    pf_full_d = !flush & (pf_full_q ? !pop : arrive & !pop);
    pf_d = (arrive & !pf_full_q) ? dmem_q : pf_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      pipe_q <= '0;
      fcnt_q <= '0;
      pf_q <= '0;
      pf_full_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      pipe_q <= pipe_d;
      fcnt_q <= fcnt_d;
      pf_q <= pf_d;
      pf_full_q <= pf_full_d;
    end
  end
endmodule

// File: rtl/dmem_img_reader.sv
// dmem_img_reader: fetches one packed 28x28 frame from dmem and streams its pixels with row/col/last tags
module dmem_img_reader
  import img_pkg::*;
#(
  parameter logic [DMEM_AW-1:0] BASE_ADDR = 7'd1,
  parameter int RD_LAT = 1
) (
  input  logic               pxlclk,
  input  logic               rst_n,
  input  logic               iStart,
  input  logic               iAbort,
  output logic               oDmem_rden,
  output logic [DMEM_AW-1:0] oDmem_addr,
  input  logic [255:0]       iDmem_q,
  output logic               oPxl_valid,
  input  logic               iPxl_ready,
  output logic [15:0]        oPxl_data,
  output logic [4:0]         oPxl_row,
  output logic [4:0]         oPxl_col,
  output logic               oPxl_last,
  output logic               oBusy,
  output logic               oDone
);
  rd_state_t state_q, state_d;
  logic start_q, valid_q, valid_d;
  logic [3:0] idx_q, idx_d;
  logic [9:0] cnt_q, cnt_d;
  logic [4:0] row_q, row_d, col_q, col_d;
  pix_word_t cur_q, cur_d, pf_word;
  logic launch, run, hs, last_hs, pop, full, col_end;
  dmem_word_prefetch #(.BASE_ADDR(BASE_ADDR), .RD_LAT(RD_LAT)) u_pf (
    .clk(pxlclk),
    .rst_n(rst_n),
    .req(run & !iAbort),
    .pop(pop),
    .flush(!run | iAbort),
    .dmem_q(iDmem_q),
    .rden(oDmem_rden),
    .addr(oDmem_addr),
    .full(full),
    .word(pf_word)
  );
  always_comb begin
    launch = (state_q == IDLE) & iStart & !start_q;
    run = state_q == RUN;
    hs = valid_q & iPxl_ready;
    last_hs = hs & (cnt_q == 10'(NUM_PIX - 1));
    col_end = col_q == 5'(IMG_W - 1);
    pop = run & !iAbort & full & !last_hs & (!valid_q | (hs & (idx_q == 4'(PIX_PER_WORD - 1))));
    state_d = iAbort ? IDLE : launch ? RUN : (run & last_hs) ? DONE : (state_q == DONE) ? IDLE : state_q;
    valid_d = run & !iAbort & (pop | (valid_q & !(hs & ((idx_q == 4'(PIX_PER_WORD - 1)) | last_hs))));
    cur_d = pop ? pf_word : cur_q;
    idx_d = launch ? '0 : idx_q + 4'(hs);
    cnt_d = launch ? '0 : cnt_q + 10'(hs);
    col_d = launch ? '0 : hs ? (col_end ? '0 : col_q + 5'd1) : col_q;
    row_d = launch ? '0 : (hs & col_end) ? row_q + 5'd1 : row_q;
    oPxl_valid = valid_q;
    oPxl_data = valid_q ? cur_q[{idx_q, 4'd0} +: 16] : '0;
    oPxl_row = valid_q ? row_q : '0;
    oPxl_col = valid_q ? col_q : '0;
    oPxl_last = valid_q & (cnt_q == 10'(NUM_PIX - 1));
    oBusy = run;
    oDone = state_q == DONE;
  end
  always_ff @(posedge pxlclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cur_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= iStart;
      valid_q <= valid_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      col_q <= col_d;
      cur_q <= cur_d;
    end
  end
endmodule

// File: tb/tb_dmem_img_reader.sv
// tb_dmem_img_reader: random-ready frame reads checked against a pixel-index model of the expected stream
module tb_dmem_img_reader;
  logic clk = 1'b0, rst_n, start, abort, ready;
  logic [255:0] dq;
  logic rden, valid, last, busy, done;
  logic [6:0] addr;
  logic [15:0] data;
  logic [4:0] row, col;
  int checks = 0, errors = 0;
  int exp_p, rd_cnt, done_cnt, cyc, first_v, last_hs_cyc, rmode, stall_cnt;
  bit chk_en = 0, stall_q, prev_last_hs;
  logic [15:0] hold_d;
  dmem_img_reader dut (
    .pxlclk(clk), .rst_n(rst_n), .iStart(start), .iAbort(abort),
    .oDmem_rden(rden), .oDmem_addr(addr), .iDmem_q(dq),
    .oPxl_valid(valid), .iPxl_ready(ready), .oPxl_data(data),
    .oPxl_row(row), .oPxl_col(col), .oPxl_last(last),
    .oBusy(busy), .oDone(done)
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mem_word(input logic [6:0] a);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = 16'(32'hA000 + 16 * (int'(a) - 1) + i);
    return w;
  endfunction
  function automatic logic [255:0] junk();
    logic [255:0] w;
    for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
    return w;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic reset_model();
    exp_p = 0; rd_cnt = 0; done_cnt = 0; cyc = 0; first_v = -1; last_hs_cyc = -1;
    stall_q = 0; prev_last_hs = 0; stall_cnt = 0;
  endtask
  task automatic launch(input bit hold);
    @(posedge clk); #1;
    reset_model();
    start = 1;
    @(posedge clk); #1;
    start = hold;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("done_seen", done_cnt, 1);
    check("beats_total", exp_p, 784);
    check("rden_total", rd_cnt, 49);
  endtask
  task automatic wait_pix(input int n);
    for (int i = 0; i < 5000 && exp_p < n; i++) @(posedge clk);
    check("reach_pixel", exp_p >= n, 1);
  endtask
  initial begin
    dq = '0;
    forever begin
      @(posedge clk);
      dq <= rden ? mem_word(addr) : junk();
    end
  end
  initial begin
    ready = 1;
    forever begin
      @(posedge clk); #1;
      if (rmode == 1) ready = 1'($urandom_range(0, 1));
      else if (rmode == 2 && exp_p == 15 && stall_cnt < 100) begin ready = 0; stall_cnt++; end
      else ready = 1;
    end
  end
  always @(negedge clk) if (chk_en) begin
    cyc++;
    if (rden) begin
      check("rden_addr", addr, 1 + rd_cnt);
      rd_cnt++;
    end
    if (stall_q) begin
      check("hold_valid", valid, 1);
      check("hold_data", data, hold_d);
    end
    if (done) begin
      done_cnt++;
      check("done_after_last", prev_last_hs, 1);
    end
    if (valid) begin
      if (first_v < 0) first_v = cyc;
      check("pix_data", data, 32'hA000 + exp_p);
      check("pix_row", row, exp_p / 28);
      check("pix_col", col, exp_p % 28);
      check("pix_last", last, exp_p == 783);
      if (exp_p == 28) begin check("tag28_row", row, 1); check("tag28_col", col, 0); end
      if (exp_p == 783) begin check("tag783_row", row, 27); check("tag783_col", col, 27); end
      if (ready) begin
        if (exp_p == 783) last_hs_cyc = cyc;
        exp_p++;
      end
    end
    prev_last_hs = valid & ready & last;
    stall_q = valid & !ready;
    hold_d = data;
  end
  initial begin
    rst_n = 0; start = 0; abort = 0; rmode = 0;
    reset_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {valid, rden, busy, done, last}, 0);
    check("rst_data", {data, row, col, addr}, 0);
    @(posedge clk); #1 rst_n = 1;
    chk_en = 1;
    rmode = 0;
    launch(0);
    wait_done();
    check("first_valid_latency", first_v - 1, 3);
    check("back_to_back", last_hs_cyc - first_v, 783);
    rmode = 1;
    launch(0);
    wait_done();
    rmode = 2;
    launch(0);
    for (int i = 0; i < 2000 && stall_cnt < 100; i++) @(posedge clk);
    check("stall_reached", stall_cnt, 100);
    check("stall_words", rd_cnt <= 2, 1);
    check("stall_pixel", data, 16'hA00F);
    wait_done();
    rmode = 0;
    launch(0);
    wait_pix(300);
    abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    launch(0);
    wait_done();
    launch(1);
    repeat (60) @(posedge clk);
    #1 start = 0;
    @(posedge clk); #1 start = 1;
    wait_done();
    repeat (200) @(posedge clk);
    check("held_one_frame", done_cnt, 1);
    check("held_beats", exp_p, 784);
    check("held_reads", rd_cnt, 49);
    start = 0;
    launch(0);
    wait_pix(100);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("async_rst_outs", {valid, rden, busy, done, last}, 0);
    check("async_rst_data", {data, row, col, addr}, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (20) @(posedge clk);
    check("rst_no_done", done_cnt, 0);
    check("rst_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
